// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave for port 0 (RW) of the management SRAM wrapper.
// Decodes the address window, drives SRAM controls combinationally in IDLE, and registers read data and ack.
module wb_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF_F800,
    parameter int unsigned READ_WAIT  = 0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  sram_clk,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [3:0]            sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_din,
    input  logic [31:0]           sram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        ACK
    } state_e;

    localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

    state_e      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] dat_q, dat_d;
    logic        req, hit;

    // Gating with reset keeps the SRAM deselected while reset is held, whatever the bus does.
    assign req = wb_rstn_i & wb_cyc_i & wb_stb_i & (state_q == IDLE);
    assign hit = req & ((wb_adr_i & ADDR_MASK) == BASE_ADDR);

    assign sram_clk   = wb_clk_i;
    assign sram_csb   = ~(hit & (~wb_we_i | (|wb_sel_i)));
    assign sram_web   = ~(hit & wb_we_i);
    assign sram_wmask = (hit & wb_we_i) ? wb_sel_i : 4'b0000;
    assign sram_addr  = wb_adr_i[ADDR_WIDTH+1:2];
    assign sram_din   = wb_dat_i;

    assign wb_ack_o = (state_q == ACK);
    assign wb_dat_o = dat_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wb_we_i | ~hit) begin
                        state_d = ACK;
                        if (!hit) dat_d = '0;
                    end else begin
                        state_d = RD;
                        wait_d  = '0;
                    end
                end
            end
            RD: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    dat_d   = sram_dout;
                    state_d = ACK;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench: two controllers (READ_WAIT 0 and 3) on a shared bus, each with its own SRAM model.
module tb_wb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;

    logic [31:0] dat_o0, din0, dout0, dat_o3, din3, dout3;
    logic        ack0, sclk0, csb0, web0, ack3, sclk3, csb3, web3;
    logic [3:0]  wmask0, wmask3;
    logic [8:0]  addr0, addr3;

    logic [31:0] mem0 [512];
    logic [31:0] mem3 [512];

    wb_sram_ctrl #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .ADDR_MASK(32'hFFFF_F800), .READ_WAIT(0)) dut0 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o0), .wb_ack_o(ack0),
        .sram_clk(sclk0), .sram_csb(csb0), .sram_web(web0), .sram_wmask(wmask0),
        .sram_addr(addr0), .sram_din(din0), .sram_dout(dout0));

    wb_sram_ctrl #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .ADDR_MASK(32'hFFFF_F800), .READ_WAIT(3)) dut3 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o3), .wb_ack_o(ack3),
        .sram_clk(sclk3), .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3),
        .sram_addr(addr3), .sram_din(din3), .sram_dout(dout3));

    // Behavioural SRAMs: masked byte writes, read data valid after the sampling edge.
    always @(posedge sclk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) mem0[addr0][8*i +: 8] <= din0[8*i +: 8];
            end else begin
                dout0 <= mem0[addr0];
            end
        end
    end

    always @(posedge sclk3) begin
        if (!csb3) begin
            if (!web3) begin
                for (int i = 0; i < 4; i++)
                    if (wmask3[i]) mem3[addr3][8*i +: 8] <= din3[8*i +: 8];
            end else begin
                dout3 <= mem3[addr3];
            end
        end
    end

    bit          use3;
    logic        m_ack, m_csb, m_web;
    logic [3:0]  m_wmask;
    logic [8:0]  m_addr;
    logic [31:0] m_dat;
    assign m_ack   = use3 ? ack3   : ack0;
    assign m_csb   = use3 ? csb3   : csb0;
    assign m_web   = use3 ? web3   : web0;
    assign m_wmask = use3 ? wmask3 : wmask0;
    assign m_addr  = use3 ? addr3  : addr0;
    assign m_dat   = use3 ? dat_o3 : dat_o0;

    typedef struct {
        bit          use3;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        csb;
        logic        web;
        logic [3:0]  wmask;
        logic [8:0]  addr;
        int          lat;
        logic [31:0] rdat;
        bit          chkdat;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] dat;
        bit          chk;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit u3, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic c, logic wb, logic [3:0] wm, logic [8:0] ad, int l,
                                logic [31:0] rd, bit cd);
        vec_t v;
        v.use3 = u3; v.we = w; v.adr = a; v.wdat = d; v.sel = s; v.csb = c; v.web = wb;
        v.wmask = wm; v.addr = ad; v.lat = l; v.rdat = rd; v.chkdat = cd;
        return v;
    endfunction

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
    endtask

    // Entered just after a rising edge; leaves just after a rising edge with one idle cycle behind.
    task automatic access(input string tag, input vec_t v);
        exp_t e;
        int   k;
        int   lows;
        bit   got;
        use3 = v.use3;
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat = v.wdat; sel = v.sel;
        e.lat = v.lat; e.dat = v.rdat; e.chk = v.chkdat;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, " csb"}, {31'd0, m_csb}, {31'd0, v.csb});
        chk({tag, " web"}, {31'd0, m_web}, {31'd0, v.web});
        chk({tag, " wmask"}, {28'd0, m_wmask}, {28'd0, v.wmask});
        if (!v.csb) chk({tag, " addr"}, {23'd0, m_addr}, {23'd0, v.addr});
        lows = 0;
        got  = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (m_csb === 1'b0) lows++;
            if (m_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ack within 20 cycles, required latency %0d", tag, e.lat);
        end else begin
            chk({tag, " latency"}, 32'(k), 32'(e.lat));
            if (e.chk) chk({tag, " dat_o"}, m_dat, e.dat);
        end
        chk({tag, " csb pulses"}, 32'(lows), v.csb ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk({tag, " ack single"}, {31'd0, m_ack}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          ack_cnt;
        int          lows;
        logic [9:0]  low_map, exp_map;
        exp_t        e;

        for (int i = 0; i < 512; i++) begin
            mem0[i] = '0;
            mem3[i] = '0;
        end
        dout0 = '0;
        dout3 = '0;
        use3  = 1'b0;
        bus_idle();
        rstn = 1'b0;

        vecs[0]  = mk(0, 1, 32'h10,  32'hDEADBEEF, 4'b0101, 0, 0, 4'b0101, 9'd4,   1, 32'h0,        0);
        vecs[1]  = mk(0, 0, 32'h10,  32'h0,        4'b0000, 0, 1, 4'b0000, 9'd4,   2, 32'h00AD00EF, 1);
        vecs[2]  = mk(0, 1, 32'h7FC, 32'h12345678, 4'b1111, 0, 0, 4'b1111, 9'd511, 1, 32'h0,        0);
        vecs[3]  = mk(0, 1, 32'h13,  32'hCAFEF00D, 4'b1010, 0, 0, 4'b1010, 9'd4,   1, 32'h0,        0);
        vecs[4]  = mk(0, 1, 32'h10,  32'hFFFFFFFF, 4'b0000, 1, 0, 4'b0000, 9'd4,   1, 32'h0,        0);
        vecs[5]  = mk(0, 0, 32'h12,  32'h0,        4'b0000, 0, 1, 4'b0000, 9'd4,   2, 32'hCAADF0EF, 1);
        vecs[6]  = mk(1, 0, 32'h7FC, 32'h0,        4'b0000, 0, 1, 4'b0000, 9'd511, 5, 32'h12345678, 1);
        vecs[7]  = mk(0, 0, 32'h800, 32'h0,        4'b1111, 1, 1, 4'b0000, 9'd0,   1, 32'h0,        1);
        vecs[8]  = mk(0, 1, 32'h804, 32'hFFFFFFFF, 4'b1111, 1, 1, 4'b0000, 9'd1,   1, 32'h0,        1);
        vecs[9]  = mk(0, 0, 32'h7FC, 32'h0,        4'b0000, 0, 1, 4'b0000, 9'd511, 2, 32'h12345678, 1);
        vecs[10] = mk(1, 0, 32'h13,  32'h0,        4'b0000, 0, 1, 4'b0000, 9'd4,   5, 32'hCAADF0EF, 1);

        // Reset held with random bus activity.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            cyc = 1'($urandom); stb = 1'($urandom); we = 1'($urandom);
            sel = 4'($urandom); dat = $urandom; adr = $urandom_range(0, 32'hFFF);
            @(negedge clk);
            chk($sformatf("rst%0d ack", c),   {30'd0, ack0, ack3}, 32'd0);
            chk($sformatf("rst%0d dat_o", c), dat_o0 | dat_o3, 32'd0);
            chk($sformatf("rst%0d csb", c),   {30'd0, csb0, csb3}, 32'd3);
            chk($sformatf("rst%0d web", c),   {30'd0, web0, web3}, 32'd3);
            chk($sformatf("rst%0d wmask", c), {24'd0, wmask0, wmask3}, 32'd0);
        end
        @(posedge clk); #1;
        bus_idle();
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            access($sformatf("vec%0d", i), vecs[i]);
            if (i == 8) begin
                chk("miss write mem0[1]", mem0[1], 32'h0);
                chk("miss write mem3[1]", mem3[1], 32'h0);
            end
        end

        // Back-to-back reads with stb held: csb low at C0,C3,C6,C9 and ack at C2,C5,C8.
        use3 = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h7FC; sel = 4'h0;
        for (int k = 2; k < 10; k += 3) begin
            e.lat = k; e.dat = 32'h12345678; e.chk = 1'b1;
            sb.push_back(e);
        end
        low_map = '0;
        exp_map = '0;
        ack_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            low_map[k] = (csb0 === 1'b0);
            exp_map[k] = ((k % 3) == 0);
            if (ack0 === 1'b1) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b extra ack: ack at cycle %0d, required none", k);
                end else begin
                    e = sb.pop_front();
                    chk("b2b ack cycle", 32'(k), 32'(e.lat));
                    chk("b2b dat_o", dat_o0, e.dat);
                end
            end
            @(posedge clk); #1;
        end
        bus_idle();
        chk("b2b csb map", {22'd0, low_map}, {22'd0, exp_map});
        chk("b2b ack count", 32'(ack_cnt), 32'd3);
        sb.delete();
        repeat (12) @(posedge clk);
        #1;

        // Abort by dropping cyc in RD on the wait-state controller.
        access("pre-abort", vecs[6]);
        use3 = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10;
        @(posedge clk); #1;
        bus_idle();
        ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack3 === 1'b1) ack_cnt++;
        end
        chk("abort no ack", 32'(ack_cnt), 32'd0);
        chk("abort dat_o held", dat_o3, 32'h12345678);
        @(posedge clk); #1;
        access("post-abort", vecs[10]);

        // Reset asserted mid-RD.
        use3 = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst ack",   {30'd0, ack0, ack3}, 32'd0);
        chk("midrst dat_o", dat_o3, 32'd0);
        chk("midrst csb",   {30'd0, csb0, csb3}, 32'd3);
        chk("midrst web",   {30'd0, web0, web3}, 32'd3);
        chk("midrst wmask", {24'd0, wmask0, wmask3}, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        rstn = 1'b1;
        ack_cnt = 0;
        lows    = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack3 === 1'b1) ack_cnt++;
            if (csb3 === 1'b0) lows++;
        end
        chk("midrst no ack after", 32'(ack_cnt), 32'd0);
        chk("midrst no sram access", 32'(lows), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
